// File: rtl/wb_regfile_if.sv
// Signal bundle between the MEM/WB pipeline register, the decode stage and wb_regfile.
// The slave modport is the register file; the master modport is the pipeline side.
interface wb_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
);
    logic              regwriteW;
    logic              memtoregW;
    logic [DATA_W-1:0] rdW;
    logic [DATA_W-1:0] aluoutW;
    logic [ADDR_W-1:0] writeregW;
    logic [ADDR_W-1:0] ra1D;
    logic [ADDR_W-1:0] ra2D;
    logic [DATA_W-1:0] rd1D;
    logic [DATA_W-1:0] rd2D;
    logic [DATA_W-1:0] resultW;
    logic [CNT_W-1:0]  wbcount;

    modport slave (
        input  regwriteW, memtoregW, rdW, aluoutW, writeregW, ra1D, ra2D,
        output rd1D, rd2D, resultW, wbcount
    );

    modport master (
        output regwriteW, memtoregW, rdW, aluoutW, writeregW, ra1D, ra2D,
        input  rd1D, rd2D, resultW, wbcount
    );
endinterface

// File: rtl/wb_regfile.sv
// Write-back result select, 32-entry register file with two async read ports and a retired-write counter.
// Optional macro REGFILE_BYPASS_EN forwards the in-flight write-back value to matching read ports.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    wb_regfile_if.slave  bus
);
    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] result;
    logic              commit;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;

    assign result = bus.memtoregW ? bus.rdW : bus.aluoutW;
    assign commit = bus.regwriteW && (bus.writeregW != '0);

    // Entry 0 is cleared on reset and never written, so it stays zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[bus.writeregW] <= result;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (commit) begin
            count <= count + CNT_W'(1);
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic bypass1;
    logic bypass2;

    assign bypass1 = reset_n && commit && (bus.writeregW == bus.ra1D);
    assign bypass2 = reset_n && commit && (bus.writeregW == bus.ra2D);

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (bypass1) begin
            rd1 = result;
        end else if (bus.ra1D != '0) begin
            rd1 = regs[bus.ra1D];
        end
        if (bypass2) begin
            rd2 = result;
        end else if (bus.ra2D != '0) begin
            rd2 = regs[bus.ra2D];
        end
    end
`else
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (bus.ra1D != '0) begin
            rd1 = regs[bus.ra1D];
        end
        if (bus.ra2D != '0) begin
            rd2 = regs[bus.ra2D];
        end
    end
`endif

    assign bus.resultW = result;
    assign bus.rd1D    = rd1;
    assign bus.rd2D    = rd2;
    assign bus.wbcount = count;
endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed vector table, hand sequences and randomized traffic
// checked against an array-based register file model. A second instance with CNT_W=4 covers counter wrap.
module tb_wb_regfile;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        logic        rw;
        logic        mt;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wr;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] exp_result;
        logic [31:0] exp_rd1;
        logic [31:0] exp_rd2;
        logic [31:0] exp_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;

    int checks = 0;
    int errors = 0;

    logic [31:0] mreg [32];
    logic [31:0] mcnt;

    always #5 clk = ~clk;

    wb_regfile_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(32)) bus ();
    wb_regfile_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(4))  bus4 ();

    assign bus4.regwriteW = bus.regwriteW;
    assign bus4.memtoregW = bus.memtoregW;
    assign bus4.rdW       = bus.rdW;
    assign bus4.aluoutW   = bus.aluoutW;
    assign bus4.writeregW = bus.writeregW;
    assign bus4.ra1D      = bus.ra1D;
    assign bus4.ra2D      = bus.ra2D;

    wb_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    wb_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(4)) dut4 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus4.slave)
    );

    function automatic logic [31:0] modelResult();
        return bus.memtoregW ? bus.rdW : bus.aluoutW;
    endfunction

    function automatic logic [31:0] modelRead(input logic [4:0] a);
        if (a == 5'd0 || !reset_n) return 32'd0;
        if (BYPASS && bus.regwriteW && bus.writeregW != 5'd0 && bus.writeregW == a)
            return modelResult();
        return mreg[a];
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
        mcnt = 32'd0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic rw, input logic mt, input logic [31:0] rd,
                                 input logic [31:0] alu, input logic [4:0] wr,
                                 input logic [4:0] ra1, input logic [4:0] ra2);
        bus.regwriteW = rw;
        bus.memtoregW = mt;
        bus.rdW       = rd;
        bus.aluoutW   = alu;
        bus.writeregW = wr;
        bus.ra1D      = ra1;
        bus.ra2D      = ra2;
    endtask

    // Advance one rising edge, committing into the model with the inputs seen at that edge.
    task automatic tick();
        @(posedge clk);
        if (reset_n && bus.regwriteW && bus.writeregW != 5'd0) begin
            mreg[bus.writeregW] = modelResult();
            mcnt = mcnt + 32'd1;
        end
        #1;
    endtask

    task automatic stepAndCheck(input string tag);
        #2;
        checkOutput({tag, " resultW"}, bus.resultW, modelResult());
        checkOutput({tag, " rd1D"}, bus.rd1D, modelRead(bus.ra1D));
        checkOutput({tag, " rd2D"}, bus.rd2D, modelRead(bus.ra2D));
        tick();
        checkOutput({tag, " wbcount"}, bus.wbcount, mcnt);
        checkOutput({tag, " wbcount4"}, {28'd0, bus4.wbcount}, {28'd0, mcnt[3:0]});
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs [6];

        vecs[0] = '{1'b1, 1'b0, 32'h1111_1111, 32'hDEAD_BEEF, 5'd7,  5'd7, 5'd0,
                    32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000, 32'd1};
        vecs[1] = '{1'b1, 1'b1, 32'hCAFE_F00D, 32'h0000_0000, 5'd31, 5'd7, 5'd31,
                    32'hCAFE_F00D, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'd2};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 5'd0,  5'd0, 5'd31,
                    32'hFFFF_FFFF, 32'h0000_0000, 32'hCAFE_F00D, 32'd2};
        vecs[3] = '{1'b0, 1'b1, 32'h1234_5678, 32'h0000_0000, 5'd7,  5'd7, 5'd7,
                    32'h1234_5678, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'd2};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0005, 5'd3,  5'd3, 5'd31,
                    32'h0000_0005, 32'h0000_0005, 32'hCAFE_F00D, 32'd3};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_00A0, 32'h0000_0000, 5'd7,  5'd3, 5'd7,
                    32'h0000_00A0, 32'h0000_0005, 32'h0000_00A0, 32'd4};

        reset_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        modelReset();
        #3;
        checkOutput("reset rd1D", bus.rd1D, 32'd0);
        checkOutput("reset wbcount", bus.wbcount, 32'd0);
        #4 reset_n = 1'b1;
        tick();

        // Directed table: combinational result before the edge, array and counter after it.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].rw, vecs[i].mt, vecs[i].rd, vecs[i].alu,
                          vecs[i].wr, vecs[i].ra1, vecs[i].ra2);
            #2;
            checkOutput($sformatf("vec%0d resultW", i), bus.resultW, vecs[i].exp_result);
            tick();
            checkOutput($sformatf("vec%0d rd1D", i), bus.rd1D, vecs[i].exp_rd1);
            checkOutput($sformatf("vec%0d rd2D", i), bus.rd2D, vecs[i].exp_rd2);
            checkOutput($sformatf("vec%0d wbcount", i), bus.wbcount, vecs[i].exp_cnt);
        end

        // Same-cycle read of the register being written.
        applyStimulus(1'b1, 1'b0, 32'd0, 32'h0000_000A, 5'd9, 5'd0, 5'd0);
        tick();
        applyStimulus(1'b1, 1'b0, 32'd0, 32'h0000_000B, 5'd9, 5'd9, 5'd9);
        #2;
        checkOutput("samecycle rd1D pre", bus.rd1D, BYPASS ? 32'h0000_000B : 32'h0000_000A);
        checkOutput("samecycle rd2D pre", bus.rd2D, BYPASS ? 32'h0000_000B : 32'h0000_000A);
        tick();
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd9, 5'd9);
        #2;
        checkOutput("samecycle rd1D post", bus.rd1D, 32'h0000_000B);
        checkOutput("samecycle rd2D post", bus.rd2D, 32'h0000_000B);
        tick();

        // Randomized traffic against the model.
        for (int n = 0; n < 300; n++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom), $urandom, $urandom,
                          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                          5'($urandom_range(0, 31)));
            stepAndCheck("rand");
        end

        // Asynchronous reset in mid-cycle clears reads and counter with no clock edge.
        applyStimulus(1'b1, 1'b0, 32'd0, 32'h0000_1234, 5'd5, 5'd0, 5'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd5, 5'd5);
        #2;
        checkOutput("prereset rd1D", bus.rd1D, 32'h0000_1234);
        #1;
        reset_n = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'd0, 32'h0000_9999, 5'd5, 5'd5, 5'd5);
        #1;
        checkOutput("async reset rd1D", bus.rd1D, 32'd0);
        checkOutput("async reset wbcount", bus.wbcount, 32'd0);
        checkOutput("async reset wbcount4", {28'd0, bus4.wbcount}, 32'd0);
        modelReset();
        tick();
        checkOutput("held reset rd2D", bus.rd2D, 32'd0);
        checkOutput("held reset wbcount", bus.wbcount, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd5, 5'd0);
        #2 reset_n = 1'b1;
        #1;
        checkOutput("after reset rd1D", bus.rd1D, 32'd0);
        tick();

        // Counter wrap on the 4-bit instance: 16 commits return it to zero, idle cycles hold it.
        for (int n = 0; n < 16; n++) begin
            applyStimulus(1'b1, 1'b0, 32'd0, 32'(n + 100), 5'(n + 1), 5'(n + 1), 5'd0);
            stepAndCheck("wrap");
        end
        checkOutput("wrap wbcount4 zero", {28'd0, bus4.wbcount}, 32'd0);
        checkOutput("wrap wbcount 16", bus.wbcount, 32'd16);
        for (int n = 0; n < 3; n++) begin
            applyStimulus(1'b0, 1'b1, $urandom, $urandom, 5'd4, 5'd4, 5'd16);
            stepAndCheck("idle");
        end
        checkOutput("idle wbcount4 held", {28'd0, bus4.wbcount}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
